// File: rtl/thor2024_io_initiator.sv
// Single-outstanding initiator for I/O and config-space bus cycles with a request/response handshake.
// Define THOR2024_IO_INIT_TIMEOUT_EN to abort bus cycles that receive no ack_i within TIMEOUT cycles.
module thor2024_io_initiator #(
    parameter logic [15:0] TIMEOUT = 16'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_cfg_i,
    input  logic        req_we_i,
    input  logic [7:0]  req_sel_i,
    input  logic [31:0] req_adr_i,
    input  logic [63:0] req_dat_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic        resp_err_o,
    output logic [63:0] resp_dat_o,
    output logic        cs_config_o,
    output logic        cs_io_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [7:0]  sel_o,
    output logic [31:0] adr_o,
    output logic [63:0] dat_o,
    input  logic        ack_i,
    input  logic [63:0] dat_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t state;

`ifdef THOR2024_IO_INIT_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_hit;

    assign tmo_hit = (tmo_cnt == TIMEOUT);
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign resp_err_o     = 1'b0;
`endif

    assign req_ready_o = (state == IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            we_o         <= 1'b0;
            cs_config_o  <= 1'b0;
            cs_io_o      <= 1'b0;
            sel_o        <= '0;
            adr_o        <= '0;
            dat_o        <= '0;
            resp_valid_o <= 1'b0;
            resp_dat_o   <= '0;
`ifdef THOR2024_IO_INIT_TIMEOUT_EN
            resp_err_o   <= 1'b0;
            tmo_cnt      <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        state       <= BUS;
                        cyc_o       <= 1'b1;
                        stb_o       <= 1'b1;
                        we_o        <= req_we_i;
                        cs_config_o <= req_cfg_i;
                        cs_io_o     <= ~req_cfg_i;
                        sel_o       <= req_sel_i;
                        adr_o       <= req_adr_i;
                        dat_o       <= req_dat_i;
`ifdef THOR2024_IO_INIT_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                    end
                end
                BUS: begin
                    // An ack in the same cycle as the timeout still counts as a normal completion.
                    if (ack_i) begin
                        state        <= RESP;
                        cyc_o        <= 1'b0;
                        stb_o        <= 1'b0;
                        we_o         <= 1'b0;
                        cs_config_o  <= 1'b0;
                        cs_io_o      <= 1'b0;
                        resp_valid_o <= 1'b1;
                        resp_dat_o   <= we_o ? '0 : dat_i;
`ifdef THOR2024_IO_INIT_TIMEOUT_EN
                        resp_err_o   <= 1'b0;
`endif
                    end
`ifdef THOR2024_IO_INIT_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state        <= RESP;
                        cyc_o        <= 1'b0;
                        stb_o        <= 1'b0;
                        we_o         <= 1'b0;
                        cs_config_o  <= 1'b0;
                        cs_io_o      <= 1'b0;
                        resp_valid_o <= 1'b1;
                        resp_dat_o   <= '1;
                        resp_err_o   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
